ats21_client: RTL and testbench
===============================

ATS21_CLIENT -- requirements
Module: ats21_client

Interface
REQ-001 Parameter READY_TIMEOUT, default 15: max cycles in WAIT_RDY before a timeout response (1..255).
REQ-002 Parameter RESP_LAT, default 3: cycles after the low half is driven until stat is sampled (1..255).
REQ-003 Port clk  input  1  single clock; all logic rising-edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port cmd_valid  input  1  host offers a 32-bit ATS21 instruction.
REQ-006 Port cmd_ready  output  1  client can accept a command (high only in IDLE).
REQ-007 Port cmd_word  input  32  instruction; [31:29] opcode, rest per ATS21 format.
REQ-008 Port rsp_valid  output  1  one-cycle pulse; response fields valid.
REQ-009 Port rsp_status  output  2  sampled status: Ack=0, Error=1, Nack=2.
REQ-010 Port rsp_timeout  output  1  qualifies rsp_valid; ATS21 never raised ready.
REQ-011 Port req  output  1  request to the ATS21.
REQ-012 Port ready  input  1  ATS21 is reading ctrl halves.
REQ-013 Port ctrl  output  16  instruction half to the ATS21.
REQ-014 Port stat  input  2  ATS21 status for this client.
REQ-015 Port data  input  24  ATS21 alarm/timer finished bits.
REQ-016 Port alarm_pending  output  24  sticky per-alarm event flags.
REQ-017 Port alarm_clear  input  24  per-bit clear of alarm_pending.

Function
REQ-018 FSM states IDLE, REQ, WAIT_RDY, SEND_LO, WAIT_RSP, RESP; all outputs registered.
REQ-019 IDLE: cmd_ready=1, ctrl=0, req=0; cmd_valid&cmd_ready latches cmd_word, next REQ.
REQ-020 REQ: req=1 for exactly one cycle, ctrl=cmd[31:16]; next WAIT_RDY.
REQ-021 WAIT_RDY: ctrl=cmd[31:16]; at the edge where ready=1, next SEND_LO.
REQ-022 WAIT_RDY: wait counter clears on entry; if READY_TIMEOUT cycles elapse with ready=0, next RESP with timeout flag set.
REQ-023 SEND_LO: ctrl=cmd[15:0] for exactly one cycle; next WAIT_RSP.
REQ-024 WAIT_RSP: ctrl=0; latency counter counts RESP_LAT cycles, then stat is captured and next RESP.
REQ-025 RESP: rsp_valid=1 for one cycle; rsp_status=captured stat (Nack=2 on timeout); rsp_timeout=timeout flag; next IDLE.
REQ-026 Command to response, ready on first WAIT_RDY cycle: rsp_valid rises exactly 4+RESP_LAT cycles after the cmd accept edge.
REQ-027 rsp_status, rsp_timeout hold their values until the next RESP; rsp_valid is 0 outside RESP.
REQ-028 ready while in IDLE, REQ, SEND_LO or WAIT_RSP is ignored; stat value 3 is reported unchanged.
REQ-029 Counters are 8 bits and saturate; they never wrap.
REQ-030 alarm_pending[i] sets on a 0->1 transition of data[i] (previous-cycle copy registered).
REQ-031 alarm_pending[i] clears when alarm_clear[i]=1; a simultaneous set wins.
REQ-032 Alarm latching runs in every FSM state, independent of command traffic.
REQ-033 A new command is accepted no earlier than the cycle after RESP (one outstanding command).

Reset
REQ-034 reset=1 at a clock edge forces IDLE and clears all counters and the latched command.
REQ-035 Reset values: cmd_ready=0 during reset then 1, req=0, ctrl=0, rsp_valid=0, rsp_status=2 (Nack), rsp_timeout=0, alarm_pending=0.
REQ-036 Reset mid-transaction aborts it; no rsp_valid is produced for the aborted command.
REQ-037 The data edge-history register resets to 0, so a data bit already high at reset release sets alarm_pending on the first cycle.

Structure
REQ-038 Package ats21_pkg holds the status encoding (Ack/Error/Nack), the opcode constants, the ATS21 field widths (16-bit ctrl, 24 alarms) and the FSM state type.
REQ-039 Sub-module ats21_alarm_latch (24-bit edge detect + sticky set/clear) holds the alarm logic; the FSM stays in ats21_client.

Verification
REQ-040 Reset, then cmd 0x2A00_1234 and ready at the first WAIT_RDY edge -> req 1 cycle; ctrl 0x2A00 then 0x1234; stat=0 -> rsp_valid at accept+7, rsp_status=0, rsp_timeout=0.
REQ-041 ready held 0 -> rsp_valid exactly READY_TIMEOUT cycles after WAIT_RDY entry, rsp_status=2, rsp_timeout=1; ctrl never shows the low half.
REQ-042 ready arrives 5 cycles late -> ctrl holds the high half throughout, low half appears for one cycle after ready; stat=1 -> rsp_status=1.
REQ-043 reset pulsed during WAIT_RSP -> no rsp_valid, cmd_ready=1 the cycle after reset drops, next command completes normally.
REQ-044 data[5] 0->1 with alarm_clear[5]=1 on the same edge -> alarm_pending[5]=1; clear on the next cycle -> 0; data[5] held high -> no re-set.

Source files
------------

// File: rtl/ats21_pkg.sv
// Shared ATS21 client definitions: field widths, status encoding, opcodes and FSM state type.
package ats21_pkg;

    localparam int unsigned CMD_W   = 32;
    localparam int unsigned CTRL_W  = 16;
    localparam int unsigned ALARM_W = 24;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        STAT_ACK   = 2'd0,
        STAT_ERROR = 2'd1,
        STAT_NACK  = 2'd2
    } ats21_stat_e;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_SET_TIMER  = 3'd1;
    localparam logic [2:0] OP_SET_ALARM  = 3'd2;
    localparam logic [2:0] OP_READ_TIMER = 3'd3;
    localparam logic [2:0] OP_CLR_ALARM  = 3'd4;
    localparam logic [2:0] OP_CONFIG     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RDY,
        S_SEND_LO,
        S_WAIT_RSP,
        S_RESP
    } ats21_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ats21_client_if.sv
// Host command/response and ATS21 bus signals of one client; slave = client, master = environment.
interface ats21_client_if;
    import ats21_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [CMD_W-1:0]   cmd_word;
    logic               rsp_valid;
    logic [1:0]         rsp_status;
    logic               rsp_timeout;
    logic               req;
    logic               ready;
    logic [CTRL_W-1:0]  ctrl;
    logic [1:0]         stat;
    logic [ALARM_W-1:0] data;
    logic [ALARM_W-1:0] alarm_pending;
    logic [ALARM_W-1:0] alarm_clear;

    modport slave (
        input  cmd_valid, cmd_word, ready, stat, data, alarm_clear,
        output cmd_ready, rsp_valid, rsp_status, rsp_timeout, req, ctrl, alarm_pending
    );

    modport master (
        output cmd_valid, cmd_word, ready, stat, data, alarm_clear,
        input  cmd_ready, rsp_valid, rsp_status, rsp_timeout, req, ctrl, alarm_pending
    );

endinterface

// File: rtl/ats21_alarm_latch.sv
// Rising-edge detect on the ATS21 alarm/timer bits with sticky per-bit pending flags.
module ats21_alarm_latch
    import ats21_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [ALARM_W-1:0] i_data,
    input  logic [ALARM_W-1:0] i_clear,
    output logic [ALARM_W-1:0] o_pending
);

    logic [ALARM_W-1:0] r_prev;
    logic [ALARM_W-1:0] r_pending;
    logic [ALARM_W-1:0] w_rise;

    assign w_rise    = i_data & ~r_prev;
    assign o_pending = r_pending;

    // A rising edge on the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev    <= i_data;
            r_pending <= (r_pending & ~i_clear) | w_rise;
        end
    end

endmodule

// File: rtl/ats21_client.sv
// ATS21 client: sends a 32-bit instruction as two 16-bit halves and returns the sampled status.
module ats21_client
    import ats21_pkg::*;
#(
    parameter int unsigned READY_TIMEOUT = 15,
    parameter int unsigned RESP_LAT      = 3
) (
    input  logic          clk,
    input  logic          reset,
    ats21_client_if.slave bus
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LAT     = CNT_W'(RESP_LAT);

    ats21_state_e       r_state;
    logic [CMD_W-1:0]   r_cmd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cmd_ready;
    logic               r_req;
    logic [CTRL_W-1:0]  r_ctrl;
    logic               r_rsp_valid;
    logic [1:0]         r_rsp_status;
    logic               r_rsp_timeout;
    logic [ALARM_W-1:0] w_pending;

    assign bus.cmd_ready     = r_cmd_ready;
    assign bus.req           = r_req;
    assign bus.ctrl          = r_ctrl;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_status    = r_rsp_status;
    assign bus.rsp_timeout   = r_rsp_timeout;
    assign bus.alarm_pending = w_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cmd         <= '0;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b0;
            r_req         <= 1'b0;
            r_ctrl        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_status  <= STAT_NACK;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_req       <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_cmd       <= bus.cmd_word;
                        r_cmd_ready <= 1'b0;
                        r_req       <= 1'b1;
                        r_ctrl      <= bus.cmd_word[31:16];
                        r_state     <= S_REQ;
                    end else begin
                        r_cmd_ready <= 1'b1;
                        r_ctrl      <= '0;
                    end
                end
                S_REQ: begin
                    r_cnt   <= '0;
                    r_ctrl  <= r_cmd[31:16];
                    r_state <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    // ready on the final waiting edge still counts as a handshake.
                    if (bus.ready) begin
                        r_ctrl  <= r_cmd[15:0];
                        r_state <= S_SEND_LO;
                    end else if (r_cnt == TO_LAST) begin
                        r_ctrl        <= '0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_status  <= STAT_NACK;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt  <= sat_inc(r_cnt);
                        r_ctrl <= r_cmd[31:16];
                    end
                end
                S_SEND_LO: begin
                    r_cnt   <= '0;
                    r_ctrl  <= '0;
                    r_state <= S_WAIT_RSP;
                end
                S_WAIT_RSP: begin
                    r_ctrl <= '0;
                    if (r_cnt == LAT) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_status  <= bus.stat;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                S_RESP: begin
                    r_ctrl      <= '0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_ctrl      <= '0;
                    r_cmd_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    ats21_alarm_latch u_alarm (
        .clk       (clk),
        .reset     (reset),
        .i_data    (bus.data),
        .i_clear   (bus.alarm_clear),
        .o_pending (w_pending)
    );

endmodule

// File: tb/tb_ats21_client.sv
// Directed bench for ats21_client: timeline model of each transaction plus literal expectations.
module tb_ats21_client;

    localparam int TO  = 15;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ats21_client_if bus();

    ats21_client #(.READY_TIMEOUT(TO), .RESP_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outputs as a function of edges since accept (k) and the edge where ready was taken (r).
    bit          m_init = 1'b0;
    bit          m_busy, m_fin;
    int          m_k, m_r;
    logic [31:0] m_cmd;
    logic        e_cmd_ready, e_req, e_rsp_valid, e_timeout;
    logic [15:0] e_ctrl;
    logic [1:0]  e_status;
    logic [23:0] e_pend, m_prev;

    always @(posedge clk) begin
        m_init = 1'b1;
        if (reset) begin
            m_busy = 1'b0; m_fin = 1'b0;
            e_cmd_ready = 1'b0; e_req = 1'b0; e_rsp_valid = 1'b0; e_timeout = 1'b0;
            e_ctrl = 16'h0; e_status = 2'd2; e_pend = 24'h0; m_prev = 24'h0;
        end else begin
            e_pend = (e_pend & ~bus.alarm_clear) | (bus.data & ~m_prev);
            m_prev = bus.data;
            e_req = 1'b0;
            e_rsp_valid = 1'b0;
            if (!m_busy) begin
                if (bus.cmd_valid && e_cmd_ready) begin
                    m_busy = 1'b1; m_fin = 1'b0; m_k = 0; m_r = -1;
                    m_cmd = bus.cmd_word;
                    e_cmd_ready = 1'b0; e_req = 1'b1; e_ctrl = m_cmd[31:16];
                end else begin
                    e_cmd_ready = 1'b1; e_ctrl = 16'h0;
                end
            end else if (m_fin) begin
                m_busy = 1'b0; e_cmd_ready = 1'b1; e_ctrl = 16'h0;
            end else begin
                m_k++;
                if (m_r < 0) begin
                    if (m_k >= 2 && bus.ready) begin
                        m_r = m_k; e_ctrl = m_cmd[15:0];
                    end else if (m_k == 1 + TO) begin
                        e_rsp_valid = 1'b1; e_status = 2'd2; e_timeout = 1'b1; e_ctrl = 16'h0; m_fin = 1'b1;
                    end else begin
                        e_ctrl = m_cmd[31:16];
                    end
                end else begin
                    e_ctrl = 16'h0;
                    if (m_k == m_r + LAT + 2) begin
                        e_rsp_valid = 1'b1; e_status = bus.stat; e_timeout = 1'b0; m_fin = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("cmp_cmd_ready",     bus.cmd_ready,     e_cmd_ready);
            chk("cmp_req",           bus.req,           e_req);
            chk("cmp_ctrl",          bus.ctrl,          e_ctrl);
            chk("cmp_rsp_valid",     bus.rsp_valid,     e_rsp_valid);
            chk("cmp_rsp_status",    bus.rsp_status,    e_status);
            chk("cmp_rsp_timeout",   bus.rsp_timeout,   e_timeout);
            chk("cmp_alarm_pending", bus.alarm_pending, e_pend);
        end
    end

    logic [15:0] ctrl_log [64];
    logic        req_log  [64];

    // d: ready is sampled on the (2+d)-th edge after accept; hold keeps ready high throughout.
    task automatic run_cmd(input logic [31:0] w, input int d, input bit hold, input logic [1:0] st,
                           input int exp_lat, input logic [1:0] exp_st, input logic exp_to);
        int n;
        int guard;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_before", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_word = w; bus.stat = st; bus.ready = hold;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_word = 32'hDEAD_BEEF;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 300) begin
            if (n < 64) begin
                ctrl_log[n] = bus.ctrl;
                req_log[n]  = bus.req;
            end
            bus.ready = hold || (n == 1 + d);
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", n, exp_lat);
        chk("rsp_status",  bus.rsp_status, exp_st);
        chk("rsp_timeout", bus.rsp_timeout, exp_to);
        bus.ready = 1'b0;
        @(negedge clk);
        chk("rsp_valid_drop",  bus.rsp_valid, 0);
        chk("cmd_ready_after", bus.cmd_ready, 1);
    endtask

    initial begin
        int lo_hits;
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_word = 32'h0; bus.ready = 1'b0; bus.stat = 2'd0;
        bus.data = 24'h000001; bus.alarm_clear = 24'h0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", bus.cmd_ready, 0);
        chk("reset_rsp_status", bus.rsp_status, 2);
        chk("reset_alarm", bus.alarm_pending, 24'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("alarm_high_at_release", bus.alarm_pending, 24'h000001);
        chk("cmd_ready_after_reset", bus.cmd_ready, 1);
        bus.data = 24'h0; bus.alarm_clear = 24'h000001;
        @(negedge clk);
        chk("alarm_clear0", bus.alarm_pending, 24'h0);
        bus.alarm_clear = 24'h0;

        // Basic transaction, ready on the first waiting edge.
        run_cmd(32'h2A00_1234, 0, 1'b0, 2'd0, 7, 2'd0, 1'b0);
        chk("t1_req0",  req_log[0], 1);
        chk("t1_req1",  req_log[1], 0);
        chk("t1_ctrl0", ctrl_log[0], 16'h2A00);
        chk("t1_ctrl1", ctrl_log[1], 16'h2A00);
        chk("t1_ctrl2", ctrl_log[2], 16'h1234);
        chk("t1_ctrl3", ctrl_log[3], 16'h0000);

        // Timeout; ready during REQ must be ignored.
        run_cmd(32'h4000_5555, -1, 1'b0, 2'd0, 1 + TO, 2'd2, 1'b1);
        lo_hits = 0;
        for (int i = 0; i < 1 + TO; i++) if (ctrl_log[i] == 16'h5555) lo_hits++;
        chk("t2_no_low_half", lo_hits, 0);

        // Ready five cycles late, Error status.
        run_cmd(32'h6ABC_0F0F, 5, 1'b0, 2'd1, 12, 2'd1, 1'b0);
        chk("t3_ctrl6", ctrl_log[6], 16'h6ABC);
        chk("t3_ctrl7", ctrl_log[7], 16'h0F0F);
        chk("t3_ctrl8", ctrl_log[8], 16'h0000);

        // Ready held high everywhere, stat value 3 passed through.
        run_cmd(32'hA123_4567, 0, 1'b1, 2'd3, 7, 2'd3, 1'b0);

        // Alarm set/clear interplay on bit 5.
        bus.data = 24'h000020; bus.alarm_clear = 24'h000020;
        @(negedge clk);
        chk("alarm5_set_wins", bus.alarm_pending, 24'h000020);
        @(negedge clk);
        chk("alarm5_cleared", bus.alarm_pending, 24'h0);
        bus.alarm_clear = 24'h0;
        repeat (3) @(negedge clk);
        chk("alarm5_no_reset", bus.alarm_pending, 24'h0);
        bus.data = 24'hA50020;
        @(negedge clk);
        chk("alarm_multi", bus.alarm_pending, 24'hA50000);
        bus.alarm_clear = 24'h050000;
        @(negedge clk);
        chk("alarm_partial_clear", bus.alarm_pending, 24'hA00000);
        bus.alarm_clear = 24'h0; bus.data = 24'h0;

        // Reset during WAIT_RSP aborts the command.
        while (bus.cmd_ready !== 1'b1) @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_word = 32'h6000_0001; bus.ready = 1'b1; bus.stat = 2'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.ready = 1'b0;
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_cmd_ready_in_reset", bus.cmd_ready, 0);
        @(negedge clk);
        chk("abort_cmd_ready_after", bus.cmd_ready, 1);
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_rsp", bus.rsp_valid, 0);
        end
        run_cmd(32'h2A00_1234, 0, 1'b0, 2'd0, 7, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
